// File: rtl/control_pkg.sv
// control_pkg: opcode, alu_op and step encodings shared by the control unit and its bench
package control_pkg;
  localparam logic [2:0] OP_MV = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  function automatic logic is_alu(logic [2:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_AND;
  endfunction
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction source, datapath flag and datapath control bundle; master = datapath side, slave = control unit
interface control_fsm_if #(
  parameter int NUM_REGS = 8,
  localparam int REG_BITS = $clog2(NUM_REGS),
  localparam int IW = 3 + 2*REG_BITS
);
  logic run;
  logic [IW-1:0] iin;
  logic g_nonzero;
  logic [NUM_REGS-1:0] r_select;
  logic immediate_select;
  logic g_select;
  logic [NUM_REGS-1:0] r_enable;
  logic ir_enable;
  logic a_enable;
  logic g_enable;
  logic [1:0] alu_op;
  logic done;
  logic busy;
  modport master (
    output run, iin, g_nonzero,
    input r_select, immediate_select, g_select, r_enable, ir_enable, a_enable, g_enable, alu_op, done, busy
  );
  modport slave (
    input run, iin, g_nonzero,
    output r_select, immediate_select, g_select, r_enable, ir_enable, a_enable, g_enable, alu_op, done, busy
  );
endinterface

// File: rtl/reg_decoder.sv
// reg_decoder: register index to one-hot (idx in, en in, onehot out), all zeros when en is low
module reg_decoder #(
  parameter int NUM_REGS = 8,
  localparam int REG_BITS = $clog2(NUM_REGS)
) (
  input  logic [REG_BITS-1:0] idx,
  input  logic en,
  output logic [NUM_REGS-1:0] onehot
);
  assign onehot = en ? {{(NUM_REGS-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle step FSM with internal IR (clock, reset, bus: run/iin/g_nonzero in, selects/enables/alu_op/done/busy out)
module control_fsm
  import control_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int REG_BITS = $clog2(NUM_REGS),
  localparam int IW = 3 + 2*REG_BITS
) (
  input logic clock,
  input logic reset,
  control_fsm_if.slave bus
);
  step_t step, step_n;
  logic [IW-1:0] ir;
  logic [2:0] op;
  logic [REG_BITS-1:0] x, y;
  logic [NUM_REGS-1:0] x_oh, y_oh;
  logic act, alu, y_sel, x_wr;
  assign op = ir[IW-1:IW-3];
  assign x = ir[IW-4:REG_BITS];
  assign y = ir[REG_BITS-1:0];
  assign act = !reset;
  assign alu = is_alu(op);
  assign y_sel = act && ((step == T1 && (op == OP_MV || op == OP_MVNZ)) || (step == T2 && alu));
  assign x_wr = act && ((step == T1 && (op == OP_MV || op == OP_MVI || (op == OP_MVNZ && bus.g_nonzero))) || step == T3);
  reg_decoder #(.NUM_REGS(NUM_REGS)) dec_x (.idx(x), .en(act), .onehot(x_oh));
  reg_decoder #(.NUM_REGS(NUM_REGS)) dec_y (.idx(y), .en(y_sel), .onehot(y_oh));
  always_ff @(posedge clock) begin
    if (reset) begin
      step <= T0;
      ir <= '0;
    end else begin
      step <= step_n;
      if (step == T0 && bus.run) ir <= bus.iin;
    end
  end
  always_comb begin
    step_n = step == T0 ? (bus.run ? T1 : T0) : step == T1 ? (alu ? T2 : T0) : step == T2 ? T3 : T0;
    bus.r_select = y_oh | (act && step == T1 && alu ? x_oh : '0);
    bus.r_enable = x_wr ? x_oh : '0;
    bus.immediate_select = act && step == T1 && op == OP_MVI;
    bus.g_select = act && step == T3;
    bus.ir_enable = act && step == T0 && bus.run;
    bus.a_enable = act && step == T1 && alu;
    bus.g_enable = act && step == T2;
    bus.alu_op = act && step == T2 ? (op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_ADD) : ALU_ADD;
    bus.done = act && ((step == T1 && !alu) || step == T3);
    bus.busy = act && step != T0;
  end
endmodule
